// File: rtl/pulse_sched_pkg.sv
// Shared types for the actuator pulse scheduler.
// FSM state encoding and H-bridge pair codes.
package pulse_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SETUP,
    S_PULSE,
    S_DEAD,
    S_DONE
  } state_t;

  localparam logic [1:0] BR_OFF = 2'b00;
  localparam logic [1:0] BR_FWD = 2'b10;
  localparam logic [1:0] BR_REV = 2'b01;

endpackage

// File: rtl/pulse_sched_if.sv
// Control/matrix bundle between system, memory ctrl and scheduler.
// master: drives request/config, slave: the scheduler driving pins.
interface pulse_sched_if #(
  parameter int ROWS  = 5,
  parameter int COLS  = 2,
  parameter int CNT_W = 32
);

  logic                   start_n;
  logic                   system_enable_n;
  logic [ROWS*COLS-1:0]   cells_state;
  logic                   cell_invert;
  logic [CNT_W-1:0]       ccr0;
  logic [CNT_W-1:0]       ccr1;
  logic                   busy;
  logic                   update_done;
  logic [ROWS-1:0]        rows;
  logic [COLS-1:0]        cols;
  logic [ROWS-1:0]        rows_enable;
  logic [COLS-1:0]        cols_enable;
  logic [2*ROWS-1:0]      rows_hbrige;
  logic [2*COLS-1:0]      cols_hbrige;

  modport master (
    output start_n, system_enable_n,
    output cells_state, cell_invert,
    output ccr0, ccr1,
    input  busy, update_done,
    input  rows, cols,
    input  rows_enable, cols_enable,
    input  rows_hbrige, cols_hbrige
  );

  modport slave (
    input  start_n, system_enable_n,
    input  cells_state, cell_invert,
    input  ccr0, ccr1,
    output busy, update_done,
    output rows, cols,
    output rows_enable, cols_enable,
    output rows_hbrige, cols_hbrige
  );

endinterface

// File: rtl/pulse_timer.sv
// Phase down-counter; a load of 0 counts as 1 cycle.
// Ports: clock, reset_n, load, load_val in; expired out.
module pulse_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (load_val == '0) ? CNT_W'(1) : load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // last cycle of the loaded phase
  assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/pulse_scheduler.sv
// Drives changed matrix cells one by one with dead/pulse/dead.
// Ports: clock, reset_n, bus (pulse_sched_if.slave).
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int ROWS  = 5,
  parameter int COLS  = 2,
  parameter int CNT_W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  pulse_sched_if.slave bus
);

  localparam int N  = ROWS * COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  state_t            state;
  logic [N-1:0]      target;
  logic [N-1:0]      applied;
  logic [IW-1:0]     idx;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [RW-1:0]     nxt_row;
  logic [CW-1:0]     nxt_col;
  logic              skip_q;
  logic              stop_q;
  logic              abort;
  logic              changed;
  logic              last;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_exp;
  logic [ROWS-1:0]   row_oh;
  logic [COLS-1:0]   col_oh;
  logic [2*ROWS-1:0] row_br;
  logic [2*COLS-1:0] col_br;

  assign abort   = bus.system_enable_n;
  assign changed = target[idx] ^ applied[idx];
  assign last    = (idx == IW'(N - 1));

  // row/col track idx so no divider is needed
  always_comb begin
    nxt_col = col + CW'(1);
    nxt_row = row;
    if (col == CW'(COLS - 1)) begin
      nxt_col = '0;
      nxt_row = row + RW'(1);
    end
  end

  always_comb begin
    row_oh = '0;
    col_oh = '0;
    row_br = '0;
    col_br = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_br[2*r +: 2] = BR_OFF;
      if (row == RW'(r)) begin
        row_oh[r]        = 1'b1;
        row_br[2*r +: 2] = target[idx] ? BR_FWD : BR_REV;
      end
    end
    for (int c = 0; c < COLS; c++) begin
      col_br[2*c +: 2] = BR_OFF;
      if (col == CW'(c)) begin
        col_oh[c]        = 1'b1;
        col_br[2*c +: 2] = target[idx] ? BR_REV : BR_FWD;
      end
    end
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = bus.ccr1;
    unique case (state)
      S_SCAN:  tmr_load = abort || changed;
      S_SETUP: begin
        tmr_load = abort || tmr_exp;
        if (!abort) tmr_val = bus.ccr0;
      end
      S_PULSE: tmr_load = abort || tmr_exp;
      default: tmr_load = 1'b0;
    endcase
  end

  pulse_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expired (tmr_exp)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      target          <= '0;
      applied         <= '0;
      idx             <= '0;
      row             <= '0;
      col             <= '0;
      skip_q          <= 1'b0;
      stop_q          <= 1'b0;
      bus.busy        <= 1'b0;
      bus.update_done <= 1'b0;
      bus.rows        <= '0;
      bus.cols        <= '0;
      bus.rows_enable <= '0;
      bus.cols_enable <= '0;
      bus.rows_hbrige <= '0;
      bus.cols_hbrige <= '0;
    end else begin
      bus.update_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!bus.start_n && !bus.system_enable_n) begin
            target   <= bus.cells_state ^ {N{bus.cell_invert}};
            idx      <= '0;
            row      <= '0;
            col      <= '0;
            skip_q   <= 1'b0;
            stop_q   <= 1'b0;
            bus.busy <= 1'b1;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (abort) begin
            skip_q <= 1'b1;
            stop_q <= 1'b1;
            state  <= S_DEAD;
          end else if (changed) begin
            bus.rows        <= row_oh;
            bus.cols        <= col_oh;
            bus.rows_hbrige <= row_br;
            bus.cols_hbrige <= col_br;
            state           <= S_SETUP;
          end else if (last) begin
            bus.update_done <= 1'b1;
            state           <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
            row <= nxt_row;
            col <= nxt_col;
          end
        end
        S_SETUP: begin
          if (abort) begin
            skip_q <= 1'b1;
            stop_q <= 1'b1;
            state  <= S_DEAD;
          end else if (tmr_exp) begin
            bus.rows_enable <= row_oh;
            bus.cols_enable <= col_oh;
            state           <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (abort || tmr_exp) begin
            bus.rows_enable <= '0;
            bus.cols_enable <= '0;
            state           <= S_DEAD;
          end
          if (abort) begin
            skip_q <= 1'b1;
            stop_q <= 1'b1;
          end
        end
        S_DEAD: begin
          if (abort) stop_q <= 1'b1;
          if (tmr_exp) begin
            // an abort before DEAD leaves the cell unapplied
            if (!skip_q) applied[idx] <= target[idx];
            bus.rows        <= '0;
            bus.cols        <= '0;
            bus.rows_hbrige <= '0;
            bus.cols_hbrige <= '0;
            if (stop_q || abort) begin
              bus.busy <= 1'b0;
              state    <= S_IDLE;
            end else if (last) begin
              bus.update_done <= 1'b1;
              state           <= S_DONE;
            end else begin
              idx   <= idx + IW'(1);
              row   <= nxt_row;
              col   <= nxt_col;
              state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Self-checking bench for pulse_scheduler.
// Cycle-by-cycle compare against a trace built from the cell rules.
module tb_pulse_scheduler;

  localparam int ROWS  = 5;
  localparam int COLS  = 2;
  localparam int CNT_W = 32;
  localparam int N     = ROWS * COLS;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [ROWS-1:0]   rows;
    logic [ROWS-1:0]   ren;
    logic [COLS-1:0]   cols;
    logic [COLS-1:0]   cen;
    logic [2*ROWS-1:0] rbr;
    logic [2*COLS-1:0] cbr;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  obs_t         obs;
  obs_t         exp_q[$];
  logic [N-1:0] m_applied;

  always #5 clk = ~clk;

  pulse_sched_if #(
    .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)
  ) bus ();

  pulse_scheduler #(
    .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  always_comb obs = {bus.busy, bus.update_done,
                     bus.rows, bus.rows_enable,
                     bus.cols, bus.cols_enable,
                     bus.rows_hbrige, bus.cols_hbrige};

  task automatic chk(input string tag, input obs_t got,
                     input obs_t want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  // Expected outputs while cell i (target t) is being driven.
  function automatic obs_t sel_obs(input int i, input logic t,
                                   input logic en);
    obs_t o;
    int   r;
    int   c;
    o = '0;
    r = i / COLS;
    c = i % COLS;
    o.busy    = 1'b1;
    o.rows[r] = 1'b1;
    o.cols[c] = 1'b1;
    if (en) begin
      o.ren[r] = 1'b1;
      o.cen[c] = 1'b1;
    end
    o.rbr[2*r +: 2] = t ? 2'b10 : 2'b01;
    o.cbr[2*c +: 2] = t ? 2'b01 : 2'b10;
    return o;
  endfunction

  // Trace for cycles 1.. after acceptance; last entry is idle.
  // abort_at: cycle during which system_enable_n goes high (0=none).
  task automatic build(input logic [N-1:0] tgt, input int p,
                       input int d, input int abort_at);
    obs_t ib;
    obs_t done_o;
    obs_t hold;
    int   cyc;
    bit   stop;
    bit   late;
    logic t;
    exp_q.delete();
    ib = '0;
    ib.busy = 1'b1;
    done_o = ib;
    done_o.done = 1'b1;
    hold = ib;
    cyc = 0;
    stop = 0;
    late = 0;
    for (int i = 0; i < N; i++) begin
      t = tgt[i];
      exp_q.push_back(ib);
      cyc++;
      if (cyc == abort_at) begin
        stop = 1;
        break;
      end
      if (t == m_applied[i]) continue;
      for (int k = 0; k < d + p && !stop; k++) begin
        exp_q.push_back(sel_obs(i, t, k >= d));
        cyc++;
        if (cyc == abort_at) stop = 1;
      end
      if (stop) begin
        hold = sel_obs(i, t, 1'b0);
        break;
      end
      for (int k = 0; k < d; k++) begin
        exp_q.push_back(sel_obs(i, t, 1'b0));
        cyc++;
        if (cyc == abort_at) late = 1;
      end
      m_applied[i] = t;
      if (late) break;
    end
    if (stop)
      for (int k = 0; k < d; k++) exp_q.push_back(hold);
    if (!stop && !late) exp_q.push_back(done_o);
    exp_q.push_back('0);
  endtask

  // abort_at: 0 none, -1 random (half the time), else fixed cycle
  task automatic run_scan(input logic [N-1:0] cs, input logic inv,
                          input int c0, input int c1,
                          input int abort_at, input string name);
    int p;
    int d;
    int ab;
    int len;
    logic [N-1:0] tgt;
    logic [N-1:0] save;
    p   = (c0 == 0) ? 1 : c0;
    d   = (c1 == 0) ? 1 : c1;
    tgt = cs ^ {N{inv}};
    ab  = abort_at;
    if (abort_at < 0) begin
      save = m_applied;
      build(tgt, p, d, 0);
      len = exp_q.size();
      m_applied = save;
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len) : 0;
    end
    build(tgt, p, d, ab);
    @(negedge clk);
    bus.cells_state = cs;
    bus.cell_invert = inv;
    bus.ccr0        = CNT_W'(c0);
    bus.ccr1        = CNT_W'(c1);
    bus.start_n     = 1'b0;
    @(posedge clk);
    #1;
    bus.start_n     = 1'b1;
    bus.cells_state = N'($urandom);
    bus.cell_invert = 1'($urandom);
    for (int j = 1; j <= exp_q.size(); j++) begin
      if (j == ab) bus.system_enable_n = 1'b1;
      if (j == 2) bus.start_n = 1'b0;
      if (j == 3) bus.start_n = 1'b1;
      @(negedge clk);
      chk($sformatf("%s_c%0d", name, j), obs, exp_q[j-1]);
      @(posedge clk);
      #1;
    end
    bus.system_enable_n = 1'b0;
    bus.start_n         = 1'b1;
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.start_n         = 1'b0;
    bus.system_enable_n = 1'b0;
    bus.cells_state     = '1;
    bus.cell_invert     = 1'b0;
    bus.ccr0            = '0;
    bus.ccr1            = '0;
    m_applied           = '0;

    repeat (3) begin
      @(negedge clk);
      chk("reset", obs, '0);
    end
    bus.start_n = 1'b1;
    rst_n       = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset", obs, '0);
    end

    bus.system_enable_n = 1'b1;
    bus.start_n         = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("start_disabled", obs, '0);
    end
    bus.start_n         = 1'b1;
    bus.system_enable_n = 1'b0;
    @(negedge clk);
    chk("idle_after_disabled", obs, '0);

    run_scan(N'(1), 1'b0, 4, 2, 0, "single");
    run_scan(N'(1), 1'b0, 4, 2, 0, "repeat");
    run_scan('0, 1'b1, 4, 2, 0, "invert");
    run_scan('0, 1'b0, 4, 2, 5, "abort");
    run_scan('0, 1'b0, 0, 0, 0, "zero_ccr");

    for (int s = 0; s < 16; s++)
      run_scan(N'($urandom), 1'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3),
               -1, $sformatf("rnd%0d", s));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
